// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// RV32I memory-access stage. It sits between the ALU stage latch and the
// MEM->RD/WB latch. It decodes a load or store from aInst_i and runs one
// req/ack bus transaction for it. Load data is aligned and extended, and the
// pipeline is held while the access is outstanding. Non-memory instructions
// pass straight through combinationally with no added latency.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a request that sees
// no ack within TIMEOUT_CYCLES request cycles. An aborted access reports
// mErr_o and suppresses writeback.
//
// Ports
//   clk_i         clock, all state on the rising edge
//   rstN_i        synchronous reset, active-low
//   stall_i       global pipeline stall (includes stallReq_o)
//   aPc_i         PC from the ALU latch
//   aInst_i       instruction from the ALU latch
//   aValid_i      instruction valid
//   aRegD_i       destination register
//   aRegDV_i      ALU result (writeback value for non-loads)
//   aMemAddr_i    effective byte address for the load/store
//   aStoreData_i  rs2 value for stores
//   stallReq_o    this stage needs the pipeline held
//   dReq_o        bus request, held until dAck_i
//   dWe_o         1 = store, 0 = load
//   dAddr_o       word-aligned bus address
//   dStrb_o       byte-lane enables
//   dWdata_o      lane-replicated store data
//   dAck_i        bus completes the transaction this cycle
//   dRdata_i      read data, valid with dAck_i
//   mPc_o         PC to the MEM->RD/WB latch
//   mInst_o       instruction to the MEM->RD/WB latch
//   mValid_o      valid to the MEM->RD/WB latch
//   mRegD_o       destination register (0 = no writeback)
//   mRegDV_o      writeback value
//   mErr_o        access aborted by timeout
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstN_i,
    input  logic        stall_i,
    input  logic [31:0] aPc_i,
    input  logic [31:0] aInst_i,
    input  logic        aValid_i,
    input  logic [4:0]  aRegD_i,
    input  logic [31:0] aRegDV_i,
    input  logic [31:0] aMemAddr_i,
    input  logic [31:0] aStoreData_i,
    output logic        stallReq_o,
    output logic        dReq_o,
    output logic        dWe_o,
    output logic [31:0] dAddr_o,
    output logic [3:0]  dStrb_o,
    output logic [31:0] dWdata_o,
    input  logic        dAck_i,
    input  logic [31:0] dRdata_i,
    output logic [31:0] mPc_o,
    output logic [31:0] mInst_o,
    output logic        mValid_o,
    output logic [4:0]  mRegD_o,
    output logic [31:0] mRegDV_o,
    output logic        mErr_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] rdata_q;

    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic        isLoad, isStore, isMemOp;
    logic        byteOp, halfOp;
    logic [3:0]  laneStrb;
    logic [31:0] laneWdata;
    logic [31:0] loadData;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        timeoutHit;
    logic        errFlag;

    assign funct3  = aInst_i[14:12];
    assign offset  = aMemAddr_i[1:0];
    assign isLoad  = aValid_i && (aInst_i[6:0] == 7'b0000011);
    assign isStore = aValid_i && (aInst_i[6:0] == 7'b0100011);
    assign isMemOp = isLoad || isStore;

    // Access size comes from funct3[1:0] only, so the unsigned load variants
    // share lanes with their signed twins and reserved codes fall to word.
    assign byteOp = (funct3[1:0] == 2'b00);
    assign halfOp = (funct3[1:0] == 2'b01);

    // Byte-lane enables and replicated store data. Halfwords ignore addr[0]
    // and words ignore the offset entirely; loads use the same strobes.
    always_comb begin
        laneStrb  = 4'b1111;
        laneWdata = aStoreData_i;
        if (byteOp) begin
            laneStrb  = 4'b0001 << offset;
            laneWdata = {4{aStoreData_i[7:0]}};
        end else if (halfOp) begin
            laneStrb  = 4'b0011 << {offset[1], 1'b0};
            laneWdata = {2{aStoreData_i[15:0]}};
        end
    end

    assign byteSel = rdata_q[{offset, 3'b000} +: 8];
    assign halfSel = offset[1] ? rdata_q[31:16] : rdata_q[15:0];

    // Load extension from the captured word. The address and instruction are
    // still valid here because upstream is held until this stage is done.
    always_comb begin
        case (funct3)
            3'd0:    loadData = {{24{byteSel[7]}}, byteSel};
            3'd1:    loadData = {{16{halfSel[15]}}, halfSel};
            3'd4:    loadData = {24'h0, byteSel};
            3'd5:    loadData = {16'h0, halfSel};
            default: loadData = rdata_q;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeoutHit = (state_q == REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign errFlag    = err_q;

    // Request-cycle counter and abort flag. The counter restarts in IDLE so
    // every request gets the full budget; an ack on the final cycle wins.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!dAck_i && timeoutHit) begin
                    err_d = 1'b1;
                end
            end
            DONE: begin
                if (!stall_i) begin
                    err_d = 1'b0;
                end
            end
            default: begin
                cnt_d = '0;
                err_d = 1'b0;
            end
        endcase
    end

    // Counter and error flag registers.
    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    logic unusedTimeout;

    assign unusedTimeout = (TIMEOUT_CYCLES != 0);
    assign timeoutHit    = 1'b0;
    assign errFlag       = 1'b0;
`endif

    // State register plus the read-data capture on the acking cycle.
    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == REQ) && dAck_i) begin
                rdata_q <= dRdata_i;
            end
        end
    end

    // Next-state logic. An ack outside REQ is ignored; DONE holds while the
    // pipeline is stalled so the result stays visible to the next latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (isMemOp) state_d = REQ;
            REQ:     if (dAck_i || timeoutHit) state_d = DONE;
            DONE:    if (!stall_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Pass-through is the default; memory ops bubble the output
    // until DONE, and everything handshake-related is forced low in reset.
    always_comb begin
        stallReq_o = 1'b0;
        dReq_o     = 1'b0;
        mValid_o   = aValid_i;
        mPc_o      = aPc_i;
        mInst_o    = aInst_i;
        mRegD_o    = aRegD_i;
        mRegDV_o   = aRegDV_i;
        mErr_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (isMemOp) begin
                    stallReq_o = 1'b1;
                    mValid_o   = 1'b0;
                    mRegD_o    = 5'd0;
                end
            end
            REQ: begin
                stallReq_o = 1'b1;
                dReq_o     = 1'b1;
                mValid_o   = 1'b0;
                mRegD_o    = 5'd0;
            end
            DONE: begin
                mErr_o = errFlag;
                if (isLoad && !errFlag) begin
                    mRegDV_o = loadData;
                end else begin
                    mRegD_o = 5'd0;
                end
            end
            default: begin
                mValid_o = 1'b0;
            end
        endcase
        if (!rstN_i) begin
            stallReq_o = 1'b0;
            dReq_o     = 1'b0;
            mValid_o   = 1'b0;
            mErr_o     = 1'b0;
        end
    end

    assign dWe_o    = isStore;
    assign dAddr_o  = {aMemAddr_i[31:2], 2'b00};
    assign dStrb_o  = laneStrb;
    assign dWdata_o = laneWdata;

endmodule
